// File: rtl/cfir_pkg.sv
// Shared widths and FSM state encoding for the time-multiplexed 4-tap FIR engine.
package cfir_pkg;
  localparam int DATA_W = 10;
  localparam int COEF_W = 10;
  localparam int TAPS   = 4;
  localparam int ACC_W  = DATA_W + COEF_W + 2;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
endpackage

// File: rtl/cfir_mac_sequencer_if.sv
// Sample-in / coefficient-write / result-out bundle of the FIR MAC sequencer.
interface cfir_mac_sequencer_if;
  import cfir_pkg::*;

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              coef_we;
  logic [IDX_W-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [ACC_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;

  modport slave (
    input  din, din_valid, coef_we, coef_addr, coef_data, dout_ready,
    output din_ready, dout, dout_valid, busy
  );
  modport master (
    output din, din_valid, coef_we, coef_addr, coef_data, dout_ready,
    input  din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/cfir_delay_line.sv
// Enable-gated sample delay line; tap[0] is the newest sample.
module cfir_delay_line
  import cfir_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift,
  input  logic [DATA_W-1:0]            din,
  output logic [TAPS-1:0][DATA_W-1:0]  tap
);
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        tap[k] <= '0;
      else if (shift) tap[k] <= (k == 0) ? din : tap[(k == 0) ? 0 : k-1];
    end
  end
endmodule

// File: rtl/cfir_mac_sequencer.sv
// 4-tap FIR: one shared signed multiplier stepped across the taps by a small FSM,
// result held on a valid/ready output until taken.
module cfir_mac_sequencer
  import cfir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cfir_mac_sequencer_if.slave  bus
);
  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_W-1:0]      acc, acc_nxt;
  logic [TAPS-1:0][COEF_W-1:0]  coef;
  logic [TAPS-1:0][DATA_W-1:0]  tap;
  logic signed [PROD_W-1:0]     tap_x, coef_x, prod;
  logic                         accept;

  assign bus.din_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.din_valid && bus.din_ready;

  cfir_delay_line u_dl (
    .clk   (clk),
    .rst   (rst),
    .shift (accept),
    .din   (bus.din),
    .tap   (tap)
  );

  // Widen both operands first so the product is a full-precision signed multiply.
  assign tap_x   = PROD_W'($signed(tap[idx]));
  assign coef_x  = PROD_W'($signed(coef[idx]));
  assign prod    = tap_x * coef_x;
  assign acc_nxt = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      coef           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Coefficient writes are only honoured here, so a same-edge write
          // is already in place for the sample accepted at that edge.
          if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
          if (accept) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(TAPS-1)) begin
            bus.dout       <= acc_nxt;
            bus.dout_valid <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfir_mac_sequencer.sv
// Directed bench for cfir_mac_sequencer: impulse, gating, extremes, backpressure, reset, streaming.
module tb_cfir_mac_sequencer;
  logic clk, rst;
  int   n_assert, n_fail;

  cfir_mac_sequencer_if bus();

  cfir_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_coef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(a);
    bus.coef_data = 10'(d);
    step();
    bus.coef_we   = 1'b0;
  endtask

  // One sample through the engine; optional coef[2]=7 write at acceptance or
  // during the first MAC cycle, and optional backpressure hold before the handshake.
  task automatic run(input int s, input int exp, input string tag,
                     input bit wr_now, input bit wr_mac, input int hold);
    int n;
    bus.din       = 10'(s);
    bus.din_valid = 1'b1;
    bus.coef_we   = wr_now;
    bus.coef_addr = 2'd2;
    bus.coef_data = 10'd7;
    step();
    bus.din_valid = 1'b0;
    bus.coef_we   = wr_mac;
    check({tag, "_busy"}, bus.busy, 1);
    n = 0;
    while (bus.dout_valid !== 1'b1 && n < 20) begin
      step();
      n++;
      bus.coef_we = 1'b0;
    end
    bus.coef_we = 1'b0;
    check({tag, "_lat"}, n, 4);
    check({tag, "_dout"}, $signed(bus.dout), exp);
    for (int i = 0; i < hold; i++) begin
      bus.din       = 10'd123;
      bus.din_valid = 1'b1;
      step();
      check({tag, "_hold_dout"}, $signed(bus.dout), exp);
      check({tag, "_hold_vld"}, bus.dout_valid, 1);
      check({tag, "_hold_rdy"}, bus.din_ready, 0);
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    check({tag, "_post_vld"}, bus.dout_valid, 0);
    check({tag, "_post_rdy"}, bus.din_ready, 1);
  endtask

  initial begin
    int xs[8];
    int cs[4];
    int h[4];
    int gold[8];
    int acc_cyc[8];
    int cyc, k, r, sum;
    bit accepting;

    n_assert = 0;
    n_fail   = 0;
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    bus.dout_ready = 1'b0;

    // Reset state
    #2;
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", $signed(bus.dout), 0);
    check("rst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    #1;
    check("rst_release_rdy", bus.din_ready, 1);

    // Impulse response with coef {1,2,3,4}
    load_coef(0, 1);
    load_coef(1, 2);
    load_coef(2, 3);
    load_coef(3, 4);
    run(1, 1, "imp0", 0, 0, 0);
    run(0, 2, "imp1", 0, 0, 0);
    run(0, 3, "imp2", 0, 0, 0);
    run(0, 4, "imp3", 0, 0, 0);
    run(0, 0, "imp4", 0, 0, 0);

    // Coefficient gating: write during MAC is dropped, write at acceptance lands
    run(5, 5,  "gate_a", 0, 0, 0);   // taps 5,0,0,0
    run(0, 10, "gate_b", 0, 1, 0);   // taps 0,5,0,0 ; coef[2]=7 attempted mid-MAC
    run(0, 15, "gate_c", 0, 0, 0);   // taps 0,0,5,0 -> old coef[2]=3
    run(1, 21, "gate_d", 0, 0, 0);   // taps 1,0,0,5
    run(0, 2,  "gate_e", 0, 0, 0);   // taps 0,1,0,0
    run(0, 7,  "gate_f", 1, 0, 0);   // taps 0,0,1,0 with coef[2]=7 written at acceptance

    // Negative extreme, last result held under backpressure
    for (int i = 0; i < 4; i++) load_coef(i, -512);
    run(-512, 261632,  "neg1", 0, 0, 0);
    run(-512, 524288,  "neg2", 0, 0, 0);
    run(-512, 786432,  "neg3", 0, 0, 0);
    run(-512, 1048576, "neg4", 0, 0, 10);
    // No extra acceptance during the hold: taps now 0,-512,-512,-512
    run(0, 786432, "bp_after", 0, 0, 0);

    // Reset in the middle of MAC discards the pending result
    bus.din       = 10'd7;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_din_ready", bus.din_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_dout_valid", bus.dout_valid, 0);
    check("midrst_dout", $signed(bus.dout), 0);
    step();
    rst = 1'b0;
    #1;
    check("midrst_release_rdy", bus.din_ready, 1);
    // Coefficients were cleared by reset
    run(9, 0, "midrst_coef0", 0, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;

    // Back-to-back streaming against a golden convolution
    cs = '{3, -2, 5, 1};
    xs = '{10, -3, 7, 0, -512, 511, 2, -1};
    for (int i = 0; i < 4; i++) begin
      load_coef(i, cs[i]);
      h[i] = 0;
    end
    for (int n = 0; n < 8; n++) begin
      for (int j = 3; j > 0; j--) h[j] = h[j-1];
      h[0] = xs[n];
      sum = 0;
      for (int j = 0; j < 4; j++) sum += cs[j] * h[j];
      gold[n] = sum;
    end
    cyc = 0; k = 0; r = 0;
    bus.din        = 10'(xs[0]);
    bus.din_valid  = 1'b1;
    bus.dout_ready = 1'b1;
    while (r < 8 && cyc < 200) begin
      accepting = (bus.din_ready === 1'b1) && (k < 8);
      if (accepting) acc_cyc[k] = cyc;
      if (bus.dout_valid === 1'b1) begin
        check($sformatf("stream_y%0d", r), $signed(bus.dout), gold[r]);
        r++;
      end
      step();
      cyc++;
      if (accepting) begin
        k++;
        bus.din       = (k < 8) ? 10'(xs[k]) : '0;
        bus.din_valid = (k < 8);
      end
    end
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    check("stream_count", r, 8);
    check("stream_accepts", k, 8);
    for (int i = 1; i < 8; i++)
      check($sformatf("stream_period%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cfir_mac_sequencer.md
# cfir_mac_sequencer

Time-multiplexed 4-tap FIR engine for the D_CFIR path. Each accepted 10-bit sample is shifted into an enable-gated delay line. A small FSM then steps one shared signed multiplier across the taps and accumulates the products. The filtered result is presented on a valid/ready output, which removes the four parallel multipliers a free-running tapped delay line would need.

## Interface
- DATA_W, 10, sample width, signed two's complement
- COEF_W, 10, coefficient width, signed
- TAPS, 4, number of taps and delay-line depth
- ACC_W, DATA_W+COEF_W+2 (22), accumulator/output width, signed
- CLK  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- din  in  DATA_W  input sample
- din_valid  in  1  sample offered
- din_ready  out  1  block can accept a sample this cycle
- coef_we  in  1  coefficient write strobe
- coef_addr  in  2  tap index of the coefficient write
- coef_data  in  COEF_W  coefficient value
- dout  out  ACC_W  filter result
- dout_valid  out  1  result available
- dout_ready  in  1  consumer takes the result
- busy  out  1  high whenever state != IDLE

## Operation
- Delay line tap[0..TAPS-1]:
  - tap[0] is the newest sample.
  - It shifts only when a sample is accepted (din_valid && din_ready): tap[0]<=din, tap[k]<=tap[k-1].
- Coefficient file coef[0..TAPS-1]:
  - Written at a rising edge when coef_we=1 and state is IDLE.
  - Writes while busy are dropped, not queued.
- FSM states IDLE, MAC, DONE:
  - IDLE: din_ready=1. On acceptance: acc<=0, idx<=0, go to MAC.
  - MAC: each cycle acc<=acc+sext(tap[idx]*coef[idx]) and idx<=idx+1. After the idx=TAPS-1 accumulate, dout<=final acc and go to DONE.
  - DONE: dout_valid=1 and dout holds. When dout_ready=1, go to IDLE.
- Arithmetic:
  - Product is signed DATA_W+COEF_W = 20 bits, sign-extended to ACC_W.
  - Worst case 4·2^18 = 2^20 fits 22-bit signed, so no saturation or overflow logic.
- Simultaneous coef_we and sample acceptance in IDLE: both take effect at the same edge. The MAC of that sample uses the new coefficient.
- coef_we with busy=1 and din_valid: no effect on coefficients.
- Reset (async, any state):
  - state=IDLE, taps=0, coef=0, acc=0, idx=0, dout=0, dout_valid=0.
  - din_ready is forced 0 while Reset=1. After deassertion it is 1 in the first cycle.
  - Reset during MAC or DONE discards the pending result.

## Timing
- Acceptance at edge E0. Accumulates at E1..E4. dout_valid=1 from the cycle after E4, i.e. 5 cycles after din_valid was sampled.
- Minimum sample period: 6 cycles (IDLE, 4×MAC, DONE with dout_ready=1).
- din_ready is a pure decode of state (no combinational path from din_valid or dout_ready).
- dout_valid and dout are registered. dout is stable from DONE entry until the handshake completes.
- Handshake rules:
  - dout_valid stays high until dout_ready is sampled high.
  - The result is never dropped.
  - dout_valid=0 and din_ready=1 in the cycle after the handshake.
- busy=1 from the cycle after acceptance through the DONE handshake cycle.

## Structure
- Package cfir_pkg holds:
  - Width constants DATA_W, COEF_W, TAPS, ACC_W, and the coefficient index width.
  - State enum {IDLE, MAC, DONE}.
- Sub-module cfir_delay_line: TAPS×DATA_W shift register with shift enable, async active-high Reset, parallel tap outputs.
- The FSM, coefficient file, multiplier and accumulator stay in the top module.

## Test plan
- Reset check: assert Reset mid-MAC. Required: all outputs zero, state IDLE, din_ready=0 during reset and 1 after.
- Impulse response:
  - Stimulus: coef={1,2,3,4}, then samples 1,0,0,0,0.
  - Required: dout = 1,2,3,4,0 in order, each 5 cycles after its acceptance.
- Negative extreme:
  - Stimulus: all coef=-512 (0x200), four samples of -512.
  - Required: 4th result = 1048576 (0x100000), no wrap.
- Backpressure: hold dout_ready=0 for 10 cycles with din_valid=1. Required: dout constant, dout_valid=1, din_ready=0, delay line unchanged, no extra acceptance.
- Coefficient gating:
  - Write coef[2]=7 during MAC. Required: ignored, so the next result uses the old value.
  - Write coef[2]=7 in IDLE in the same cycle as sample acceptance. Required: that sample's result uses 7.
- Back-to-back streaming: din_valid and dout_ready held high for 8 samples. Required: exactly one acceptance per 6 cycles, and results match a golden 4-tap convolution.
